// File: rtl/gates_checker.sv
// Response monitor for the 4-bit gates block: registers each accepted vector,
// recomputes the five gate outputs a cycle later, and keeps counts plus a first-failure record.
module gates_checker #(
   parameter int WIDTH = 4,
   parameter int NVEC  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] y1,
   input  logic [WIDTH-1:0] y2,
   input  logic [WIDTH-1:0] y3,
   input  logic [WIDTH-1:0] y4,
   input  logic [WIDTH-1:0] y5,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic             fail_valid,
   output logic [CNT_W-1:0] fail_vec,
   output logic [4:0]       fail_mask
);

   // state   | meaning
   // IDLE    | waiting for start, inputs ignored
   // RUN     | accepting and comparing vectors
   // DONE    | verdict held until the next start
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   localparam logic [CNT_W-1:0] NVEC_C  = CNT_W'(NVEC);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   logic [WIDTH-1:0] s1_y1_q, s1_y1_d, s1_y2_q, s1_y2_d, s1_y3_q, s1_y3_d;
   logic [WIDTH-1:0] s1_y4_q, s1_y4_d, s1_y5_q, s1_y5_d;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic [CNT_W-1:0] vec_count_q, vec_count_d, err_count_q, err_count_d;
   logic             fail_valid_q, fail_valid_d;
   logic [CNT_W-1:0] fail_vec_q, fail_vec_d;
   logic [4:0]       fail_mask_q, fail_mask_d;
   logic [4:0]       mask;

   always_comb begin
      mask    = '0;
      mask[0] = s1_y1_q != (s1_a_q & s1_b_q);
      mask[1] = s1_y2_q != (s1_a_q | s1_b_q);
      mask[2] = s1_y3_q != (s1_a_q ^ s1_b_q);
      mask[3] = s1_y4_q != ~(s1_a_q & s1_b_q);
      mask[4] = s1_y5_q != ~(s1_a_q | s1_b_q);
   end

   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      done_d       = done_q;
      pass_d       = pass_q;
      s1_valid_d   = s1_valid_q;
      s1_a_d       = s1_a_q;
      s1_b_d       = s1_b_q;
      s1_y1_d      = s1_y1_q;
      s1_y2_d      = s1_y2_q;
      s1_y3_d      = s1_y3_q;
      s1_y4_d      = s1_y4_q;
      s1_y5_d      = s1_y5_q;
      acc_cnt_d    = acc_cnt_q;
      vec_count_d  = vec_count_q;
      err_count_d  = err_count_q;
      fail_valid_d = fail_valid_q;
      fail_vec_d   = fail_vec_q;
      fail_mask_d  = fail_mask_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d      = ST_RUN;
               busy_d       = 1'b1;
               done_d       = 1'b0;
               pass_d       = 1'b0;
               s1_valid_d   = 1'b0;
               acc_cnt_d    = '0;
               vec_count_d  = '0;
               err_count_d  = '0;
               fail_valid_d = 1'b0;
               fail_vec_d   = '0;
               fail_mask_d  = '0;
            end
         end
         ST_RUN: begin
            // acc_cnt caps acceptance at NVEC even while the last compare is in flight
            s1_valid_d = in_valid && (acc_cnt_q != NVEC_C);
            if (s1_valid_d) begin
               acc_cnt_d = acc_cnt_q + CNT_ONE;
               s1_a_d    = a;
               s1_b_d    = b;
               s1_y1_d   = y1;
               s1_y2_d   = y2;
               s1_y3_d   = y3;
               s1_y4_d   = y4;
               s1_y5_d   = y5;
            end
            if (s1_valid_q) begin
               vec_count_d = vec_count_q + CNT_ONE;
               if (mask != 5'd0) begin
                  if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_ONE;
                  if (!fail_valid_q) begin
                     fail_valid_d = 1'b1;
                     fail_vec_d   = vec_count_q;
                     fail_mask_d  = mask;
                  end
               end
               if (vec_count_d == NVEC_C) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_count_d == '0);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_y1_q      <= '0;
         s1_y2_q      <= '0;
         s1_y3_q      <= '0;
         s1_y4_q      <= '0;
         s1_y5_q      <= '0;
         acc_cnt_q    <= '0;
         vec_count_q  <= '0;
         err_count_q  <= '0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= '0;
         fail_mask_q  <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         s1_valid_q   <= s1_valid_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_y1_q      <= s1_y1_d;
         s1_y2_q      <= s1_y2_d;
         s1_y3_q      <= s1_y3_d;
         s1_y4_q      <= s1_y4_d;
         s1_y5_q      <= s1_y5_d;
         acc_cnt_q    <= acc_cnt_d;
         vec_count_q  <= vec_count_d;
         err_count_q  <= err_count_d;
         fail_valid_q <= fail_valid_d;
         fail_vec_q   <= fail_vec_d;
         fail_mask_q  <= fail_mask_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign vec_count  = vec_count_q;
   assign err_count  = err_count_q;
   assign fail_valid = fail_valid_q;
   assign fail_vec   = fail_vec_q;
   assign fail_mask  = fail_mask_q;

endmodule

// File: tb/tb_gates_checker.sv
// Directed bench for gates_checker: default instance for sweeps/protocol, a small
// CNT_W=4/NVEC=15 instance for error-count saturation.
module tb_gates_checker;

   logic       clk = 1'b0;
   logic       reset, start, start2, in_valid;
   logic [3:0] a, b, y1, y2, y3, y4, y5;
   logic       busy, done, pass, fail_valid;
   logic [7:0] vec_count, err_count, fail_vec;
   logic [4:0] fail_mask;
   logic       busy2, done2, pass2, fail_valid2;
   logic [3:0] vec_count2, err_count2, fail_vec2;
   logic [4:0] fail_mask2;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   gates_checker dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .a(a), .b(b), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5),
      .busy(busy), .done(done), .pass(pass), .vec_count(vec_count),
      .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec),
      .fail_mask(fail_mask)
   );

   gates_checker #(.WIDTH(4), .NVEC(15), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid),
      .a(a), .b(b), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5),
      .busy(busy2), .done(done2), .pass(pass2), .vec_count(vec_count2),
      .err_count(err_count2), .fail_valid(fail_valid2), .fail_vec(fail_vec2),
      .fail_mask(fail_mask2)
   );

   // Vector idx of the sweep; flip XORs corruption into y1..y5 (4 bits each, y1 lowest).
   task automatic drive(input int idx, input logic [19:0] flip);
      logic [3:0] av, bv;
      av = 4'((idx + 1) >> 1);
      bv = 4'(idx >> 1);
      a  = av;
      b  = bv;
      y1 = (av & bv) ^ flip[3:0];
      y2 = (av | bv) ^ flip[7:4];
      y3 = (av ^ bv) ^ flip[11:8];
      y4 = ~(av & bv) ^ flip[15:12];
      y5 = ~(av | bv) ^ flip[19:16];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic sweep(input int n, input int bad1, input logic [19:0] f1,
                        input int bad2, input logic [19:0] f2);
      for (int i = 0; i < n; i++)
         drive(i, (i == bad1) ? f1 : ((i == bad2) ? f2 : 20'h0));
   endtask

   task automatic do_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", done); end
      total++; if (pass !== 1'b0) begin bad++; $display("FAIL rst_pass got %b want 0", pass); end
      total++; if (vec_count !== 8'd0) begin bad++; $display("FAIL rst_vec got %0d want 0", vec_count); end
      total++; if (err_count !== 8'd0) begin bad++; $display("FAIL rst_err got %0d want 0", err_count); end
      total++; if ({fail_valid, fail_vec, fail_mask} !== 14'd0) begin bad++;
         $display("FAIL rst_fail got %b/%0d/%b want 0", fail_valid, fail_vec, fail_mask); end
   endtask

   task automatic test_sweep_pass;
      do_start;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got %b want 1", busy); end
      sweep(32, -1, 20'h0, -1, 20'h0);
      total++; if (vec_count !== 8'd31 || done !== 1'b0) begin bad++;
         $display("FAIL latency got vec=%0d done=%b want vec=31 done=0", vec_count, done); end
      @(negedge clk);
      total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++;
         $display("FAIL sweep_done got done=%b busy=%b want 1/0", done, busy); end
      total++; if (pass !== 1'b1) begin bad++; $display("FAIL sweep_pass got %b want 1", pass); end
      total++; if (vec_count !== 8'd32) begin bad++; $display("FAIL sweep_vec got %0d want 32", vec_count); end
      total++; if (err_count !== 8'd0 || fail_valid !== 1'b0) begin bad++;
         $display("FAIL sweep_err got err=%0d fv=%b want 0/0", err_count, fail_valid); end
   endtask

   task automatic test_single_fault;
      do_start;
      sweep(32, 5, 20'h00100, -1, 20'h0);
      @(negedge clk);
      total++; if (err_count !== 8'd1) begin bad++; $display("FAIL single_err got %0d want 1", err_count); end
      total++; if (fail_valid !== 1'b1 || fail_vec !== 8'd5) begin bad++;
         $display("FAIL single_vec got fv=%b vec=%0d want 1/5", fail_valid, fail_vec); end
      total++; if (fail_mask !== 5'b00100) begin bad++; $display("FAIL single_mask got %b want 00100", fail_mask); end
      total++; if (pass !== 1'b0 || done !== 1'b1) begin bad++;
         $display("FAIL single_pass got pass=%b done=%b want 0/1", pass, done); end
   endtask

   task automatic test_multi_fault;
      do_start;
      sweep(32, 0, 20'hFF000, 9, 20'h00020);
      @(negedge clk);
      total++; if (fail_mask !== 5'b11000) begin bad++; $display("FAIL multi_mask got %b want 11000", fail_mask); end
      total++; if (fail_vec !== 8'd0) begin bad++; $display("FAIL multi_vec got %0d want 0", fail_vec); end
      total++; if (err_count !== 8'd2) begin bad++; $display("FAIL multi_err got %0d want 2", err_count); end
   endtask

   task automatic test_saturation;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int i = 0; i < 16; i++) drive(i, 20'h00001);
      @(negedge clk);
      total++; if (err_count2 !== 4'd15) begin bad++; $display("FAIL sat_err got %0d want 15", err_count2); end
      total++; if (vec_count2 !== 4'd15) begin bad++; $display("FAIL sat_vec got %0d want 15", vec_count2); end
      total++; if (done2 !== 1'b1 || pass2 !== 1'b0) begin bad++;
         $display("FAIL sat_done got done=%b pass=%b want 1/0", done2, pass2); end
      total++; if (fail_vec2 !== 4'd0 || fail_mask2 !== 5'b00001) begin bad++;
         $display("FAIL sat_fail got vec=%0d mask=%b want 0/00001", fail_vec2, fail_mask2); end
   endtask

   task automatic test_reset_mid_run;
      do_start;
      sweep(10, -1, 20'h0, -1, 20'h0);
      total++; if (vec_count !== 8'd9) begin bad++; $display("FAIL mid_vec got %0d want 9", vec_count); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++; if ({busy, done, pass, vec_count, err_count} !== 19'd0) begin bad++;
         $display("FAIL mid_rst got busy=%b done=%b pass=%b vec=%0d err=%0d want all 0",
                  busy, done, pass, vec_count, err_count); end
      total++; if ({fail_valid, fail_vec, fail_mask} !== 14'd0) begin bad++;
         $display("FAIL mid_rst_fail got %b/%0d/%b want 0", fail_valid, fail_vec, fail_mask); end
      for (int i = 0; i < 3; i++) drive(i, 20'h0);
      @(negedge clk);
      total++; if (vec_count !== 8'd0 || busy !== 1'b0) begin bad++;
         $display("FAIL idle_ignore got vec=%0d busy=%b want 0/0", vec_count, busy); end
      // corrupted vector alongside start must be ignored
      start = 1'b1;
      drive(0, 20'h00001);
      start = 1'b0;
      sweep(32, -1, 20'h0, -1, 20'h0);
      @(negedge clk);
      total++; if (pass !== 1'b1 || vec_count !== 8'd32 || err_count !== 8'd0) begin bad++;
         $display("FAIL fresh_run got pass=%b vec=%0d err=%0d want 1/32/0", pass, vec_count, err_count); end
   endtask

   task automatic test_protocol;
      drive(3, 20'h00001);
      @(negedge clk);
      total++; if (vec_count !== 8'd32 || done !== 1'b1 || err_count !== 8'd0) begin bad++;
         $display("FAIL done_ignore got vec=%0d done=%b err=%0d want 32/1/0", vec_count, done, err_count); end
      do_start;
      total++; if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || vec_count !== 8'd0) begin bad++;
         $display("FAIL restart got busy=%b done=%b pass=%b vec=%0d want 1/0/0/0", busy, done, pass, vec_count); end
      sweep(5, 2, 20'h00001, -1, 20'h0);
      @(negedge clk);
      do_start;
      total++; if (vec_count !== 8'd5 || err_count !== 8'd1 || busy !== 1'b1) begin bad++;
         $display("FAIL run_start got vec=%0d err=%0d busy=%b want 5/1/1", vec_count, err_count, busy); end
      for (int i = 5; i < 33; i++) drive(i, (i == 32) ? 20'h00001 : 20'h0);
      @(negedge clk);
      total++; if (vec_count !== 8'd32 || err_count !== 8'd1 || done !== 1'b1) begin bad++;
         $display("FAIL extra_vec got vec=%0d err=%0d done=%b want 32/1/1", vec_count, err_count, done); end
      total++; if (fail_vec !== 8'd2 || fail_mask !== 5'b00001) begin bad++;
         $display("FAIL proto_fail got vec=%0d mask=%b want 2/00001", fail_vec, fail_mask); end
      do_start;
      total++; if (vec_count !== 8'd0 || err_count !== 8'd0 || fail_valid !== 1'b0 || busy !== 1'b1) begin bad++;
         $display("FAIL done_restart got vec=%0d err=%0d fv=%b busy=%b want 0/0/0/1",
                  vec_count, err_count, fail_valid, busy); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0;
      a = '0; b = '0; y1 = '0; y2 = '0; y3 = '0; y4 = '0; y5 = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      test_reset;
      test_sweep_pass;
      test_single_fault;
      test_multi_fault;
      test_saturation;
      test_reset_mid_run;
      test_protocol;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gates_checker.md
# gates_checker

Self-checking response monitor for the 4-bit logic-gates block: it consumes each applied (a, b) vector together with the five gate outputs, recomputes the expected AND/OR/XOR/NAND/NOR results, and accumulates pass/fail status over a fixed-length run. It sits beside `gates_top` at the receiving end of the stimulus stream. It turns the stimulus sweep into a synthesizable, self-judging test with a single pass/fail verdict and first-failure capture.

## Interface
- `WIDTH`, 4: operand and result width.
- `NVEC`, 32: vectors per run; run ends after the NVEC-th accepted vector is compared.
- `CNT_W`, 8: width of vector and error counters; must satisfy 2^CNT_W > NVEC.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- `in_valid`  in  1  a/b/y1..y5 carry one vector this cycle.
- `a`, `b`  in  WIDTH  applied operands.
- `y1`..`y5`  in  WIDTH each  observed AND, OR, XOR, NAND, NOR outputs.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when err_count == 0.
- `vec_count`  out  CNT_W  vectors compared this run.
- `err_count`  out  CNT_W  vectors with ≥1 mismatching output, saturating.
- `fail_valid`  out  1  a first failure has been captured.
- `fail_vec`  out  CNT_W  0-based index of first failing vector.
- `fail_mask`  out  5  per-output mismatch flags of first failure, bit0 = y1 … bit4 = y5.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: `start` → RUN, clearing vec_count, err_count, fail_valid, fail_vec, fail_mask and the pipeline.
- RUN: each cycle with `in_valid` = 1 is an accepted vector; capture a, b, y1..y5 into stage-1 register (S1).
- Stage 2 (cycle after S1 load): expected values e1 = a&b, e2 = a|b, e3 = a^b, e4 = ~(a&b), e5 = ~(a|b), all WIDTH bits; mask[i] = (yi != ei). vec_count += 1; if mask ≠ 0: err_count += 1 (saturate at 2^CNT_W−1); if fail_valid = 0, load fail_vec = current vec_count (pre-increment), fail_mask = mask, fail_valid = 1.
- RUN → DONE on the cycle the compare of vector NVEC−1 completes (vec_count becomes NVEC).
- Once NVEC vectors are accepted, further `in_valid` in RUN is ignored; `in_valid` in IDLE or DONE is ignored.
- DONE: outputs held; `start` → RUN with the same clearing as from IDLE.
- `start` while in RUN is ignored.
- Fail capture is sticky for the run; later failures only increment err_count.

## Timing
- Reset values: busy 0, done 0, pass 0, vec_count 0, err_count 0, fail_valid 0, fail_vec 0, fail_mask 0; S1 valid cleared.
- `start` sampled at edge T → busy = 1 from T+1; first vector is accepted at T+1 or later.
- Vector accepted at edge N → vec_count, err_count, fail_* updated at edge N+1 (visible after N+1); fixed 2-cycle latency from the input cycle to the visible counter.
- Back-to-back `in_valid` is sustained at one vector per clock; there is no backpressure.
- Last vector accepted at edge N → done = 1, busy = 0, pass valid after edge N+1.
- `pass` is 0 outside DONE.
- Reset mid-run: on the reset edge all state returns to reset values; any vector in S1 is discarded.
- `start` and `in_valid` in the same cycle from IDLE: the vector is ignored, because it is not yet in RUN.

## Test plan
- Correct sweep: start, then 32 vectors a,b = 0..F stepped as alternating a/b increments with golden y1..y5 → done after last+1 cycle, pass = 1, vec_count = 32, err_count = 0, fail_valid = 0.
- Single fault: same sweep, y3 of vector index 5 corrupted (XOR bit0 flipped) → err_count = 1, fail_vec = 5, fail_mask = 5'b00100, pass = 0.
- Multi-output fault: vector 0 with y4 and y5 forced to 0 (a = b = 0) → fail_mask = 5'b11000, fail_vec = 0; later fault at index 9 → err_count = 2, fail_vec stays 0.
- Saturation: CNT_W = 4, NVEC = 15, every vector wrong → err_count = 15 (saturates at 15), no wrap.
- Reset mid-run: after 10 vectors, assert reset for one cycle → all outputs 0, IDLE; in_valid then ignored until start; a fresh 32-vector run passes.
- Protocol edges: in_valid pulses in IDLE, in DONE, and a 33rd vector in RUN → vec_count unchanged; start during RUN does not clear counters; start in DONE restarts with counters cleared.
